// File: rtl/calc_result_display.sv
// Output stage of the calculator: holds the last strobed sign-magnitude result
// and scans it onto a 4-digit common-anode 7-segment display ("Err" on divide-by-zero).
module calc_result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] result,
  input  logic       err,
  input  logic       result_valid,
  input  logic       clr,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic [1:0] digit_sel
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  localparam logic [1:0] D0 = 2'd0;
  localparam logic [1:0] D1 = 2'd1;
  localparam logic [1:0] D2 = 2'd2;
  localparam logic [1:0] D3 = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_ONE   = 7'h79;

  logic          sign_q;
  logic [3:0]    mag_q;
  logic          err_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  function automatic logic [6:0] dec_code(input logic [3:0] val);
    logic [6:0] c;
    case (val)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

  // Segment pattern for one digit position given the held value.
  function automatic logic [6:0] digit_code(input logic [1:0] sel, input logic sign,
                                            input logic [3:0] mag, input logic e);
    logic       tens;
    logic [3:0] units;
    logic [6:0] c;
    tens  = (mag >= 4'd10);
    units = tens ? (mag - 4'd10) : mag;
    c     = SEG_BLANK;
    if (e) begin
      case (sel)
        D0, D1:  c = SEG_R;
        D2:      c = SEG_E;
        default: c = SEG_BLANK;
      endcase
    end else begin
      case (sel)
        D0:      c = dec_code(units);
        D1:      c = tens ? SEG_ONE : SEG_BLANK;
        D2:      c = SEG_BLANK;
        default: c = (sign && (mag != 4'd0)) ? SEG_MINUS : SEG_BLANK;
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      mag_q  <= 4'd0;
      err_q  <= 1'b0;
    end else if (clr) begin
      sign_q <= 1'b0;
      mag_q  <= 4'd0;
      err_q  <= 1'b0;
    end else if (result_valid) begin
      sign_q <= result[4];
      mag_q  <= result[3:0];
      err_q  <= err;
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    state_d = state_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      case (state_q)
        D0:      state_d = D1;
        D1:      state_d = D2;
        D2:      state_d = D3;
        default: state_d = D0;
      endcase
    end
  end

  // Outputs are computed from the next scan state so an, seg and digit_sel
  // all change on the same edge.
  always_comb begin
    an_d  = ~(4'b0001 << state_d);
    seg_d = digit_code(state_d, sign_q, mag_q, err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      state_q <= D0;
      an_q    <= 4'b1110;
      seg_q   <= 7'h40;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign digit_sel = state_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Bench for calc_result_display: directed plan steps plus random strobes,
// checked every cycle against a decimal-text model of the display.
module tb_calc_result_display;

  logic       clk;
  logic       rst_n;
  logic [4:0] result;
  logic       err;
  logic       result_valid;
  logic       clr;
  logic [3:0] an;
  logic [6:0] seg;
  logic [1:0] digit_sel;

  int n_tests;
  int n_fail;
  int k;
  bit m_err;
  bit m_neg;
  int m_mag;

  calc_result_display #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .result(result), .err(err),
    .result_valid(result_valid), .clr(clr),
    .an(an), .seg(seg), .digit_sel(digit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Character shown at a position (0 = rightmost) for the held value.
  function automatic byte disp_char(input int pos, input bit e, input bit neg, input int mag);
    int v;
    if (e) begin
      case (pos)
        0, 1:    return "r";
        2:       return "E";
        default: return " ";
      endcase
    end
    v = neg ? -mag : mag;
    case (pos)
      0:       return byte'(8'h30 + mag % 10);
      1:       return (mag >= 10) ? byte'(8'h30 + mag / 10) : " ";
      2:       return " ";
      default: return (v < 0) ? "-" : " ";
    endcase
  endfunction

  function automatic logic [6:0] char_code(input byte c);
    case (c)
      "0": return 7'h40;
      "1": return 7'h79;
      "2": return 7'h24;
      "3": return 7'h30;
      "4": return 7'h19;
      "5": return 7'h12;
      "6": return 7'h02;
      "7": return 7'h78;
      "8": return 7'h00;
      "9": return 7'h10;
      "-": return 7'h3F;
      "E": return 7'h06;
      "r": return 7'h2F;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_an", 32'(an), 32'(4'b1110));
    chk("rst_seg", 32'(seg), 32'(7'h40));
    chk("rst_sel", 32'(digit_sel), 32'd0);
  endtask

  // One clock: the edge shows the digit for the new scan slot using the value
  // held before the edge, then the model captures whatever was strobed.
  task automatic cycle();
    int         sel;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    @(posedge clk);
    k++;
    sel     = (k / 4) % 4;
    exp_seg = char_code(disp_char(sel, m_err, m_neg, m_mag));
    exp_an  = 4'hF ^ (4'h1 << sel);
    if (clr) begin
      m_err = 1'b0; m_neg = 1'b0; m_mag = 0;
    end else if (result_valid) begin
      m_err = err; m_neg = result[4]; m_mag = int'(result[3:0]);
    end
    @(negedge clk);
    chk("digit_sel", 32'(digit_sel), 32'(sel));
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    result_valid = 1'b0;
    clr          = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic strobe(input logic [4:0] r, input logic e, input logic c);
    result       = r;
    err          = e;
    result_valid = 1'b1;
    clr          = c;
    cycle();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
    m_err = 1'b0; m_neg = 1'b0; m_mag = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; k = 0;
    m_err = 1'b0; m_neg = 1'b0; m_mag = 0;
    rst_n = 1'b0; result = '0; err = 1'b0; result_valid = 1'b0; clr = 1'b0;

    // Reset held for a few cycles, with junk strobes that must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      result_valid = 1'b1; result = 5'b01001;
      chk_reset_outputs();
    end
    result_valid = 1'b0;
    release_reset();
    chk_reset_outputs();
    run(8);

    // -3, then -0
    strobe(5'b10011, 1'b0, 1'b0);
    run(16);
    strobe(5'b10000, 1'b0, 1'b0);
    run(16);

    // 15, then 10
    strobe(5'b01111, 1'b0, 1'b0);
    run(16);
    strobe(5'b01010, 1'b0, 1'b0);
    run(16);

    // Error mode, then normal value again
    strobe(5'b10010, 1'b1, 1'b0);
    run(16);
    strobe(5'b00001, 1'b0, 1'b0);
    run(16);

    // clr wins over a simultaneous strobe; scan phase keeps running
    strobe(5'b01001, 1'b0, 1'b0);
    run(3);
    strobe(5'b00111, 1'b0, 1'b1);
    run(16);

    // Back-to-back strobes: the last one wins
    strobe(5'b10101, 1'b0, 1'b0);
    strobe(5'b01000, 1'b0, 1'b0);
    run(16);

    // Random strobes and clears
    for (int i = 0; i < 200; i++) begin
      result = 5'($urandom_range(0, 31));
      err    = ($urandom_range(0, 3) == 0);
      result_valid = ($urandom_range(0, 2) == 0);
      clr    = ($urandom_range(0, 7) == 0);
      cycle();
    end

    // Asynchronous reset mid-frame while showing D2 in error mode
    strobe(5'b00011, 1'b1, 1'b0);
    for (int i = 0; i < 20 && ((k / 4) % 4) != 2; i++) cycle();
    chk("pre_rst_sel", 32'(digit_sel), 32'd2);
    chk("pre_rst_seg", 32'(seg), 32'(7'h06));
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    chk_reset_outputs();
    release_reset();
    chk_reset_outputs();
    run(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
